// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: packs 32-bit big-endian message words into 512-bit
// blocks, appends the 0x80 marker, zero fill and the 64-bit bit length, and
// presents complete blocks with first/last markers over a valid/ready handshake.
module sha_msg_padder #(
   parameter int unsigned WRD_SIZE = 32,
   parameter int unsigned MSG_SIZ  = 512,
   parameter int unsigned LEN_W    = 64,
   parameter int unsigned IDX_W    = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [WRD_SIZE-1:0] i_word,
   input  logic                i_last,
   input  logic [2:0]          i_nbytes,
   output logic [MSG_SIZ-1:0]  o_blk,
   output logic                o_blk_valid,
   input  logic                i_blk_ready,
   output logic                o_blk_first,
   output logic                o_blk_last
);

   localparam int unsigned NWORDS = MSG_SIZ / WRD_SIZE;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      EMIT  = 2'd1,
      EXTRA = 2'd2
   } state_t;

   state_t                                state_q, state_d;
   logic [0:NWORDS-1][WRD_SIZE-1:0]       blk_q, blk_d;
   logic [IDX_W-1:0]                      idx_q, idx_d;
   logic [LEN_W-1:0]                      cnt_q, cnt_d;
   logic                                  first_q, first_d;
   logic                                  last_q, last_d;
   logic                                  extra_q, extra_d;
   logic                                  padpend_q, padpend_d;

   logic [2:0]                            nb;
   logic [WRD_SIZE-1:0]                   keep_mask;
   logic [WRD_SIZE-1:0]                   pad_bits;
   logic [WRD_SIZE-1:0]                   last_word;
   logic [IDX_W:0]                        pad_slot;
   logic [LEN_W-1:0]                      cnt_new;
   logic [LEN_W-1:0]                      len_fill;
   logic [LEN_W-1:0]                      len_extra;

   // Last-word shaping: clamp byte count, mask stale bytes, place the 0x80 marker
   always_comb begin
      nb = (!i_last || (i_nbytes > 3'd4)) ? 3'd4 : i_nbytes;
      keep_mask = '1;
      pad_bits  = '0;
      case (nb)
         3'd0: begin keep_mask = 32'h0000_0000; pad_bits = 32'h8000_0000; end
         3'd1: begin keep_mask = 32'hFF00_0000; pad_bits = 32'h0080_0000; end
         3'd2: begin keep_mask = 32'hFFFF_0000; pad_bits = 32'h0000_8000; end
         3'd3: begin keep_mask = 32'hFFFF_FF00; pad_bits = 32'h0000_0080; end
         default: begin keep_mask = '1; pad_bits = '0; end
      endcase
      last_word = (i_word & keep_mask) | pad_bits;
      pad_slot  = (nb == 3'd4) ? ({1'b0, idx_q} + (IDX_W+1)'(1)) : {1'b0, idx_q};
      cnt_new   = cnt_q + LEN_W'(nb);
      len_fill  = cnt_new << 3;
      len_extra = cnt_q << 3;
   end

   // Next-state and datapath update for FILL / EMIT / EXTRA
   always_comb begin
      state_d   = state_q;
      blk_d     = blk_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      first_d   = first_q;
      last_d    = last_q;
      extra_d   = extra_q;
      padpend_d = padpend_q;
      case (state_q)
         FILL: begin
            if (i_valid) begin
               cnt_d = cnt_new;
               if (!i_last) begin
                  blk_d[idx_q] = i_word;
                  idx_d        = idx_q + IDX_W'(1);
                  if (idx_q == '1) begin
                     state_d   = EMIT;
                     last_d    = 1'b0;
                     extra_d   = 1'b0;
                     padpend_d = 1'b0;
                  end
               end else begin
                  blk_d[idx_q] = last_word;
                  state_d      = EMIT;
                  // Pad slot decides whether the length fits in this block or spills
                  if (pad_slot <= 5'd13) begin
                     if (nb == 3'd4) blk_d[pad_slot[IDX_W-1:0]] = 32'h8000_0000;
                     blk_d[NWORDS-2] = len_fill[LEN_W-1 -: WRD_SIZE];
                     blk_d[NWORDS-1] = len_fill[WRD_SIZE-1:0];
                     last_d    = 1'b1;
                     extra_d   = 1'b0;
                     padpend_d = 1'b0;
                  end else if (pad_slot <= 5'd15) begin
                     if (nb == 3'd4) blk_d[pad_slot[IDX_W-1:0]] = 32'h8000_0000;
                     last_d    = 1'b0;
                     extra_d   = 1'b1;
                     padpend_d = 1'b0;
                  end else begin
                     last_d    = 1'b0;
                     extra_d   = 1'b1;
                     padpend_d = 1'b1;
                  end
               end
            end
         end
         EMIT: begin
            if (i_blk_ready) begin
               first_d = last_q;
               if (last_q) cnt_d = '0;
               idx_d   = '0;
               blk_d   = '0;
               state_d = extra_q ? EXTRA : FILL;
            end
         end
         EXTRA: begin
            if (padpend_q) blk_d[0] = 32'h8000_0000;
            blk_d[NWORDS-2] = len_extra[LEN_W-1 -: WRD_SIZE];
            blk_d[NWORDS-1] = len_extra[WRD_SIZE-1:0];
            last_d    = 1'b1;
            extra_d   = 1'b0;
            padpend_d = 1'b0;
            state_d   = EMIT;
         end
         default: state_d = FILL;
      endcase
   end

   // State and datapath registers with asynchronous abort on reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= FILL;
         blk_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         first_q   <= 1'b1;
         last_q    <= 1'b0;
         extra_q   <= 1'b0;
         padpend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         blk_q     <= blk_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         first_q   <= first_d;
         last_q    <= last_d;
         extra_q   <= extra_d;
         padpend_q <= padpend_d;
      end
   end

   assign o_ready     = (state_q == FILL);
   assign o_blk_valid = (state_q == EMIT);
   assign o_blk_first = o_blk_valid && first_q;
   assign o_blk_last  = o_blk_valid && last_q;
   assign o_blk       = blk_q;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Bench for sha_msg_padder: byte-level SHA-256 padding model, block scoreboard,
// directed length corner cases, backpressure, mid-message reset and random traffic.
module tb_sha_msg_padder;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic [31:0]  i_word = '0;
   logic         i_last = 1'b0;
   logic [2:0]   i_nbytes = '0;
   logic [511:0] o_blk;
   logic         o_blk_valid;
   logic         i_blk_ready = 1'b0;
   logic         o_blk_first;
   logic         o_blk_last;

   sha_msg_padder #(.WRD_SIZE(32), .MSG_SIZ(512), .LEN_W(64), .IDX_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_word(i_word), .i_last(i_last), .i_nbytes(i_nbytes), .o_blk(o_blk),
      .o_blk_valid(o_blk_valid), .i_blk_ready(i_blk_ready),
      .o_blk_first(o_blk_first), .o_blk_last(o_blk_last)
   );

   always #5 clk = ~clk;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [511:0] blk;
      logic         first;
      logic         last;
   } blk_t;

   blk_t exp_q[$];
   blk_t tmp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   bit   hold = 1'b0;
   blk_t mon_e;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] wd(input logic [511:0] b, input int i);
      return b[511-32*i -: 32];
   endfunction

   // Standard SHA-256 padding on a byte list, then cut into 64-byte blocks
   function automatic void model(input bq_t m);
      bq_t         p;
      logic [63:0] bits;
      int          nblk;
      blk_t        e;
      tmp_q.delete();
      p = m;
      p.push_back(8'h80);
      while ((p.size() % 64) != 56) p.push_back(8'h00);
      bits = 64'(m.size()) * 64'd8;
      for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
      nblk = p.size() / 64;
      for (int b = 0; b < nblk; b++) begin
         e = '0;
         for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = p[64*b+i];
         e.first = (b == 0);
         e.last  = (b == nblk-1);
         tmp_q.push_back(e);
      end
   endfunction

   function automatic void push_tmp();
      foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
   endfunction

   function automatic bq_t rand_msg(input int n);
      bq_t m;
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      return m;
   endfunction

   task automatic send_word(input logic [31:0] w, input logic last, input logic [2:0] nb);
      int t = 0;
      @(negedge clk);
      i_valid  = 1'b1;
      i_word   = w;
      i_last   = last;
      i_nbytes = nb;
      while (!o_ready) begin
         if (t >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: o_ready=%b required 1", o_ready);
            i_valid = 1'b0;
            return;
         end
         t++;
         @(negedge clk);
      end
      @(posedge clk);
   endtask

   task automatic send_msg(input bq_t m, input bit gaps);
      int          n, nw, bi;
      logic [31:0] w;
      logic        last;
      logic [2:0]  nb;
      n  = m.size();
      nw = (n == 0) ? 1 : (n + 3) / 4;
      for (int k = 0; k < nw; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            i_valid = 1'b0;
         end
         for (int b = 0; b < 4; b++) begin
            bi = 4*k + b;
            w[31-8*b -: 8] = (bi < n) ? m[bi] : 8'($urandom);
         end
         last = (k == nw-1);
         nb   = last ? 3'(n - 4*k) : 3'd4;
         send_word(w, last, nb);
      end
      @(negedge clk);
      i_valid = 1'b0;
      i_last  = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_pending_blocks", 512'(exp_q.size()), 512'(0));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_o_ready"}, 512'(o_ready), 512'(1));
      chk({tag, "_o_blk_valid"}, 512'(o_blk_valid), 512'(0));
      chk({tag, "_o_blk_first"}, 512'(o_blk_first), 512'(0));
      chk({tag, "_o_blk_last"}, 512'(o_blk_last), 512'(0));
      chk({tag, "_o_blk"}, o_blk, 512'(0));
   endtask

   // Scoreboard: check every presented block, randomly accept unless held
   always @(negedge clk) begin
      if (reset_n && o_blk_valid) begin
         chk("ready_low_in_emit", 512'(o_ready), 512'(0));
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_block: got valid block %h, required none", o_blk);
         end else begin
            mon_e = exp_q[0];
            chk("blk", o_blk, mon_e.blk);
            chk("blk_first", 512'(o_blk_first), 512'(mon_e.first));
            chk("blk_last", 512'(o_blk_last), 512'(mon_e.last));
         end
      end
      i_blk_ready = (!hold && $urandom_range(0, 3) != 0);
      if (reset_n && o_blk_valid && i_blk_ready && exp_q.size() != 0) void'(exp_q.pop_front());
   end

   initial begin
      bq_t          m;
      logic [511:0] cap;
      int           t;

      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("por");
      reset_n = 1'b1;

      // "abc"
      m = {8'h61, 8'h62, 8'h63};
      model(m);
      chk("pin_abc_nblk", 512'(tmp_q.size()), 512'(1));
      chk("pin_abc_w0", 512'(wd(tmp_q[0].blk, 0)), 512'(32'h6162_6380));
      chk("pin_abc_w15", 512'(wd(tmp_q[0].blk, 15)), 512'(32'h0000_0018));
      chk("pin_abc_fl", 512'({tmp_q[0].first, tmp_q[0].last}), 512'(2'b11));
      push_tmp();
      send_msg(m, 1'b0);
      drain();

      // empty message
      m = {};
      model(m);
      chk("pin_empty_nblk", 512'(tmp_q.size()), 512'(1));
      chk("pin_empty_blk", tmp_q[0].blk, {32'h8000_0000, 480'd0});
      push_tmp();
      send_msg(m, 1'b0);
      drain();

      // 55 bytes: pad and length share the block
      m = rand_msg(55);
      model(m);
      chk("pin_55_nblk", 512'(tmp_q.size()), 512'(1));
      chk("pin_55_w13lo", 512'(wd(tmp_q[0].blk, 13) & 32'hFF), 512'(32'h80));
      chk("pin_55_w14", 512'(wd(tmp_q[0].blk, 14)), 512'(0));
      chk("pin_55_w15", 512'(wd(tmp_q[0].blk, 15)), 512'(32'h1B8));
      push_tmp();
      send_msg(m, 1'b0);
      drain();

      // 56 bytes: pad in slot 14, length spills into an extra block
      m = rand_msg(56);
      model(m);
      chk("pin_56_nblk", 512'(tmp_q.size()), 512'(2));
      chk("pin_56_a_w14", 512'(wd(tmp_q[0].blk, 14)), 512'(32'h8000_0000));
      chk("pin_56_a_w15", 512'(wd(tmp_q[0].blk, 15)), 512'(0));
      chk("pin_56_a_fl", 512'({tmp_q[0].first, tmp_q[0].last}), 512'(2'b10));
      chk("pin_56_b_blk", tmp_q[1].blk, 512'(32'h1C0));
      chk("pin_56_b_fl", 512'({tmp_q[1].first, tmp_q[1].last}), 512'(2'b01));
      push_tmp();
      send_msg(m, 1'b0);
      drain();

      // 64 bytes: pad pending into the extra block
      m = rand_msg(64);
      model(m);
      chk("pin_64_nblk", 512'(tmp_q.size()), 512'(2));
      chk("pin_64_b_blk", tmp_q[1].blk, {32'h8000_0000, 448'd0, 32'h200});
      push_tmp();
      send_msg(m, 1'b1);
      drain();

      // backpressure: block held for 5 cycles, source word waits
      m = rand_msg(96);
      model(m);
      push_tmp();
      hold = 1'b1;
      fork
         send_msg(m, 1'b0);
         begin
            t = 0;
            while (!o_blk_valid && t < 200) begin
               @(negedge clk);
               t++;
            end
            chk("bp_block_seen", 512'(o_blk_valid), 512'(1));
            cap = o_blk;
            repeat (5) begin
               @(negedge clk);
               chk("bp_blk_stable", o_blk, cap);
               chk("bp_valid_held", 512'(o_blk_valid), 512'(1));
               chk("bp_ready_low", 512'(o_ready), 512'(0));
            end
            hold = 1'b0;
         end
      join
      drain();

      // reset mid-message discards partial data
      for (int k = 0; k < 5; k++) send_word($urandom, 1'b0, 3'd4);
      @(negedge clk);
      i_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      check_reset("mid_rst");
      @(negedge clk);
      reset_n = 1'b1;

      m = {8'h61, 8'h62, 8'h63};
      model(m);
      push_tmp();
      send_msg(m, 1'b0);
      drain();

      // random traffic
      for (int r = 0; r < 40; r++) begin
         m = rand_msg($urandom_range(0, 140));
         model(m);
         push_tmp();
         send_msg(m, 1'b1);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
